// File: rtl/ps2_pad_responder_pkg.sv
// Shared constants and types for the PS2 pad responder: command/response bytes,
// frame lengths and the frame-level state encoding.
package ps2_pad_pkg;

    localparam logic [7:0] CMD_START  = 8'h01;
    localparam logic [7:0] CMD_POLL   = 8'h42;
    localparam logic [7:0] ID_DIGITAL = 8'h41;
    localparam logic [7:0] ID_ANALOG  = 8'h73;
    localparam logic [7:0] PAD_READY  = 8'h5A;

    localparam logic [3:0] FRAME_LEN_DIG = 4'd5;
    localparam logic [3:0] FRAME_LEN_ANA = 4'd9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ABORT  = 2'd2
    } pad_state_t;

    function automatic logic [3:0] frame_len(input logic analog);
        return analog ? FRAME_LEN_ANA : FRAME_LEN_DIG;
    endfunction

endpackage

// File: rtl/ps2_pad_responder_if.sv
// PS2 pad link wires. master = host (joystick reader), slave = pad.
// The link has no valid/ready: the host owns scs/sclk/sdo, the pad answers on di
// and paces the host with an active-low ack_n pulse between bytes.
interface ps2_pad_responder_if;
    logic scs;
    logic sclk;
    logic sdo;
    logic di;
    logic ack_n;

    modport master (output scs, sclk, sdo, input di, ack_n);
    modport slave  (input scs, sclk, sdo, output di, ack_n);
endinterface

// File: rtl/ps2_pad_responder_sync_edge.sv
// Synchronizer for one asynchronous input plus registered rise/fall pulses.
// level_o, rise_o and fall_o are mutually aligned (all derived from prev_q).
module ps2_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_pad_responder.sv
// PS2 DualShock pad emulator: answers host polls with ID, buttons and analog axes,
// checks the 01/42 command prefix and pulses ack_n between bytes.
module ps2_pad_responder
    import ps2_pad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_DELAY   = 40,
    parameter int ACK_WIDTH   = 80
) (
    input  logic                    clk,
    input  logic                    rst,
    ps2_pad_responder_if.slave      bus,
    input  logic                    analog_mode_i,
    input  logic [15:0]             buttons_i,
    input  logic [7:0]              stick_rx_i,
    input  logic [7:0]              stick_ry_i,
    input  logic [7:0]              stick_lx_i,
    input  logic [7:0]              stick_ly_i,
    output logic                    frame_done_o,
    output logic                    cmd_error_o,
    output pad_state_t              state_o
);

    localparam int ACK_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
    localparam int CW      = $clog2(ACK_MAX + 1);

    logic scs_lvl, scs_rise, scs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic sdo_lvl, sdo_rise, sdo_fall;
    logic unused_sync;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_scs (
        .clk(clk), .rst(rst), .async_i(bus.scs),
        .level_o(scs_lvl), .rise_o(scs_rise), .fall_o(scs_fall));
    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
        .clk(clk), .rst(rst), .async_i(bus.sclk),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sdo (
        .clk(clk), .rst(rst), .async_i(bus.sdo),
        .level_o(sdo_lvl), .rise_o(sdo_rise), .fall_o(sdo_fall));

    assign unused_sync = &{1'b0, scs_lvl, sclk_lvl, sdo_rise, sdo_fall};

    pad_state_t    state_q;
    logic [2:0]    bit_cnt_q;
    logic [3:0]    byte_idx_q;
    logic [6:0]    rx_byte_q;
    logic [7:0]    tx_byte_q;
    logic          di_q;
    logic          ack_n_q;
    logic          ack_wait_q;
    logic [CW-1:0] ack_cnt_q;
    logic          frame_done_q;
    logic          cmd_error_q;
    logic          snap_analog_q;
    logic [15:0]   snap_buttons_q;
    logic [7:0]    snap_rx_q, snap_ry_q, snap_lx_q, snap_ly_q;

    logic [3:0]    next_idx;
    logic [3:0]    frame_len_w;
    logic [7:0]    rx_full;
    logic [7:0]    resp_byte;
    logic          cmd_bad;

    // rx_full is the byte as it stands once the current (8th) bit is sampled.
    always_comb begin
        next_idx    = (byte_idx_q == 4'hF) ? 4'hF : byte_idx_q + 4'd1;
        frame_len_w = frame_len(snap_analog_q);
        rx_full     = {sdo_lvl, rx_byte_q};
        case (next_idx)
            4'd1:    resp_byte = snap_analog_q ? ID_ANALOG : ID_DIGITAL;
            4'd2:    resp_byte = PAD_READY;
            4'd3:    resp_byte = snap_buttons_q[7:0];
            4'd4:    resp_byte = snap_buttons_q[15:8];
            4'd5:    resp_byte = snap_rx_q;
            4'd6:    resp_byte = snap_ry_q;
            4'd7:    resp_byte = snap_lx_q;
            4'd8:    resp_byte = snap_ly_q;
            default: resp_byte = 8'hFF;
        endcase
        if (next_idx >= frame_len_w) begin
            resp_byte = 8'hFF;
        end
        cmd_bad = ((byte_idx_q == 4'd0) && (rx_full != CMD_START)) ||
                  ((byte_idx_q == 4'd1) && (rx_full != CMD_POLL));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            bit_cnt_q      <= 3'd0;
            byte_idx_q     <= 4'd0;
            rx_byte_q      <= 7'd0;
            tx_byte_q      <= 8'hFF;
            di_q           <= 1'b1;
            ack_n_q        <= 1'b1;
            ack_wait_q     <= 1'b0;
            ack_cnt_q      <= '0;
            frame_done_q   <= 1'b0;
            cmd_error_q    <= 1'b0;
            snap_analog_q  <= 1'b0;
            snap_buttons_q <= 16'hFFFF;
            snap_rx_q      <= 8'h80;
            snap_ry_q      <= 8'h80;
            snap_lx_q      <= 8'h80;
            snap_ly_q      <= 8'h80;
        end else begin
            frame_done_q <= 1'b0;
            cmd_error_q  <= 1'b0;

            // Ack timer: ACK_DELAY cycles waiting, then ACK_WIDTH cycles low.
            if (ack_wait_q) begin
                if (ack_cnt_q == '0) begin
                    ack_wait_q <= 1'b0;
                    ack_n_q    <= 1'b0;
                    ack_cnt_q  <= CW'(ACK_WIDTH - 1);
                end else begin
                    ack_cnt_q <= ack_cnt_q - 1'b1;
                end
            end else if (!ack_n_q) begin
                if (ack_cnt_q == '0) begin
                    ack_n_q <= 1'b1;
                end else begin
                    ack_cnt_q <= ack_cnt_q - 1'b1;
                end
            end

            if (scs_rise) begin
                frame_done_q <= (state_q == SELECT) && (byte_idx_q >= frame_len_w);
                state_q      <= IDLE;
                di_q         <= 1'b1;
                ack_n_q      <= 1'b1;
                ack_wait_q   <= 1'b0;
                ack_cnt_q    <= '0;
                bit_cnt_q    <= 3'd0;
                byte_idx_q   <= 4'd0;
            end else if (scs_fall) begin
                state_q        <= SELECT;
                snap_analog_q  <= analog_mode_i;
                snap_buttons_q <= buttons_i;
                snap_rx_q      <= stick_rx_i;
                snap_ry_q      <= stick_ry_i;
                snap_lx_q      <= stick_lx_i;
                snap_ly_q      <= stick_ly_i;
                tx_byte_q      <= 8'hFF;
                di_q           <= 1'b1;
                ack_n_q        <= 1'b1;
                ack_wait_q     <= 1'b0;
                ack_cnt_q      <= '0;
                bit_cnt_q      <= 3'd0;
                byte_idx_q     <= 4'd0;
            end else if (state_q != IDLE) begin
                if (sclk_fall) begin
                    di_q <= tx_byte_q[bit_cnt_q];
                end else if (sclk_rise) begin
                    rx_byte_q <= {sdo_lvl, rx_byte_q[6:1]};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_q  <= 3'd0;
                        byte_idx_q <= next_idx;
                        if (state_q == SELECT && cmd_bad) begin
                            state_q     <= ABORT;
                            cmd_error_q <= 1'b1;
                            tx_byte_q   <= 8'hFF;
                        end else if (state_q == SELECT) begin
                            tx_byte_q <= resp_byte;
                            // No ack after the frame's last byte or past its end.
                            if (byte_idx_q < frame_len_w - 4'd1) begin
                                ack_wait_q <= 1'b1;
                                ack_cnt_q  <= CW'(ACK_DELAY - 1);
                            end
                        end else begin
                            tx_byte_q <= 8'hFF;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end
            end
        end
    end

    assign bus.di       = di_q;
    assign bus.ack_n    = ack_n_q;
    assign frame_done_o = frame_done_q;
    assign cmd_error_o  = cmd_error_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_ps2_pad_responder.sv
// Bench for ps2_pad_responder: a host driver plays poll frames on scs/sclk/sdo,
// expected di bytes go into exp_q and a monitor pops and compares each received byte.
`timescale 1ns/1ps
module tb_ps2_pad_responder;
  import ps2_pad_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int ACK_DELAY   = 40;
  localparam int ACK_WIDTH   = 80;
  localparam int GAP         = 140;
  localparam int HALF        = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        analog_mode;
  logic [15:0] buttons;
  logic [7:0]  stick_rx, stick_ry, stick_lx, stick_ly;
  logic        frame_done, cmd_error;
  pad_state_t  state;

  ps2_pad_responder_if bus ();

  ps2_pad_responder #(
    .SYNC_STAGES(SYNC_STAGES), .ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .analog_mode_i(analog_mode), .buttons_i(buttons),
    .stick_rx_i(stick_rx), .stick_ry_i(stick_ry),
    .stick_lx_i(stick_lx), .stick_ly_i(stick_ly),
    .frame_done_o(frame_done), .cmd_error_o(cmd_error), .state_o(state)
  );

  int n_vec = 0;
  int n_miss = 0;
  logic [7:0] exp_q[$];
  int ack_falls = 0;
  int fd_cnt = 0;
  int ce_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // event counters sampled on the falling clock edge
  initial begin
    logic ack_prev;
    ack_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (ack_prev && bus.ack_n === 1'b0) ack_falls++;
      ack_prev = bus.ack_n;
      if (frame_done === 1'b1) fd_cnt++;
      if (cmd_error === 1'b1) ce_cnt++;
    end
  end

  // monitor: host samples di on sclk rise, LSB first
  initial begin
    logic [7:0] cur;
    logic [7:0] e;
    int nb;
    cur = 8'h00;
    nb = 0;
    forever begin
      @(posedge bus.sclk or posedge bus.scs);
      if (bus.scs === 1'b1) begin
        nb = 0;
      end else begin
        cur = {bus.di, cur[7:1]};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL di_byte: got %02h, none expected", cur);
          end else begin
            e = exp_q.pop_front();
            check("di_byte", {24'h0, cur}, {24'h0, e});
          end
        end
      end
    end
  end

  // watchdog
  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout, want end of run");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pad(input logic am, input logic [15:0] b, input logic [31:0] sticks);
    analog_mode = am;
    buttons = b;
    {stick_rx, stick_ry, stick_lx, stick_ly} = sticks;
  endtask

  task automatic start_frame();
    @(negedge clk);
    bus.scs = 1'b0;
    clocks(10);
  endtask

  task automatic end_frame();
    clocks(10);
    bus.scs = 1'b1;
    clocks(20);
  endtask

  task automatic send_byte(input logic [7:0] cmd, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.sclk = 1'b0;
      bus.sdo = cmd[i];
      clocks(HALF);
      bus.sclk = 1'b1;
      clocks(HALF);
    end
    clocks(gap);
  endtask

  task automatic send_bytes(input logic [71:0] cmds, input int n, input int gap);
    for (int i = 0; i < n; i++) send_byte(cmds[71-8*i -: 8], 8, gap);
  endtask

  task automatic push_bytes(input logic [71:0] bytes, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(bytes[71-8*i -: 8]);
  endtask

  task automatic check_counts(input string name, input int a0, input int f0, input int c0,
                              input int ea, input int ef, input int ec);
    check({name, "_acks"}, ack_falls - a0, ea);
    check({name, "_frame_done"}, fd_cnt - f0, ef);
    check({name, "_cmd_error"}, ce_cnt - c0, ec);
    check({name, "_bytes_left"}, exp_q.size(), 0);
  endtask

  localparam logic [71:0] POLL = {8'h01, 8'h42, 56'h0};

  initial begin
    int a0, f0, c0;
    bus.scs = 1'b1;
    bus.sclk = 1'b1;
    bus.sdo = 1'b1;
    set_pad(1'b1, 16'hFFFF, 32'h80808080);

    // reset state
    clocks(3);
    check("rst_di", bus.di, 1'b1);
    check("rst_ack_n", bus.ack_n, 1'b1);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_cmd_error", cmd_error, 1'b0);
    check("rst_state", state, IDLE);
    rst = 1'b0;
    clocks(5);

    // 1: analog poll
    a0 = ack_falls; f0 = fd_cnt; c0 = ce_cnt;
    set_pad(1'b1, 16'hFFFE, 32'h808020E0);
    push_bytes(72'hFF_73_5A_FE_FF_80_80_20_E0, 9);
    start_frame();
    send_bytes(POLL, 9, GAP);
    end_frame();
    check_counts("analog", a0, f0, c0, 8, 1, 0);

    // 2: digital poll, host clocks 9 bytes
    a0 = ack_falls; f0 = fd_cnt; c0 = ce_cnt;
    set_pad(1'b0, 16'h7FFF, 32'h80808080);
    push_bytes(72'hFF_41_5A_FF_7F_FF_FF_FF_FF, 9);
    start_frame();
    send_bytes(POLL, 9, GAP);
    check("digital_fd_before_rise", fd_cnt - f0, 0);
    end_frame();
    check_counts("digital", a0, f0, c0, 4, 1, 0);

    // 3: bad start byte
    a0 = ack_falls; f0 = fd_cnt; c0 = ce_cnt;
    set_pad(1'b1, 16'h0000, 32'h11223344);
    push_bytes({24'hFF_FF_FF, 48'h0}, 3);
    start_frame();
    send_bytes({8'h81, 8'h42, 8'h00, 48'h0}, 3, GAP);
    check("badstart_state", state, ABORT);
    end_frame();
    check_counts("badstart", a0, f0, c0, 0, 0, 1);

    // 4: abort after 3 bits of byte 4, ack still low
    a0 = ack_falls; f0 = fd_cnt; c0 = ce_cnt;
    set_pad(1'b1, 16'h00FF, 32'h80808080);
    push_bytes({32'hFF_73_5A_FF, 40'h0}, 4);
    start_frame();
    send_bytes(POLL, 3, GAP);
    send_byte(8'h00, 8, 0);
    send_byte(8'h00, 3, 20);
    check("abort_ack_low", bus.ack_n, 1'b0);
    check("abort_di_low", bus.di, 1'b0);
    @(negedge clk);
    bus.scs = 1'b1;
    clocks(SYNC_STAGES + 2);
    check("abort_di", bus.di, 1'b1);
    check("abort_ack_n", bus.ack_n, 1'b1);
    check("abort_state", state, IDLE);
    clocks(20);
    check_counts("abort", a0, f0, c0, 4, 0, 0);

    a0 = ack_falls; f0 = fd_cnt; c0 = ce_cnt;
    set_pad(1'b1, 16'hA55A, 32'h11223344);
    push_bytes(72'hFF_73_5A_5A_A5_11_22_33_44, 9);
    start_frame();
    send_bytes(POLL, 9, GAP);
    end_frame();
    check_counts("after_abort", a0, f0, c0, 8, 1, 0);

    // 5: snapshot frozen during a frame
    a0 = ack_falls; f0 = fd_cnt; c0 = ce_cnt;
    set_pad(1'b0, 16'hFFFF, 32'h80808080);
    push_bytes({40'hFF_41_5A_FF_FF, 32'h0}, 5);
    start_frame();
    send_bytes(POLL, 3, GAP);
    buttons = 16'h0000;
    send_byte(8'h00, 8, GAP);
    send_byte(8'h00, 8, GAP);
    end_frame();
    check_counts("snap_a", a0, f0, c0, 4, 1, 0);
    a0 = ack_falls; f0 = fd_cnt; c0 = ce_cnt;
    push_bytes({40'hFF_41_5A_00_00, 32'h0}, 5);
    start_frame();
    send_bytes(POLL, 5, GAP);
    end_frame();
    check_counts("snap_b", a0, f0, c0, 4, 1, 0);

    // 6: reset while ack_n is low
    a0 = ack_falls; f0 = fd_cnt; c0 = ce_cnt;
    set_pad(1'b1, 16'h1234, 32'h80808080);
    push_bytes({16'hFF_73, 56'h0}, 2);
    start_frame();
    send_byte(8'h01, 8, GAP);
    send_byte(8'h42, 8, 0);
    clocks(50);
    check("rst_mid_ack_low", bus.ack_n, 1'b0);
    check("rst_mid_di_low", bus.di, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_mid_ack_n", bus.ack_n, 1'b1);
    check("rst_mid_di", bus.di, 1'b1);
    check("rst_mid_state", state, IDLE);
    clocks(3);
    rst = 1'b0;
    end_frame();
    check_counts("rst_mid", a0, f0, c0, 2, 0, 0);

    a0 = ack_falls; f0 = fd_cnt; c0 = ce_cnt;
    push_bytes(72'hFF_73_5A_34_12_80_80_80_80, 9);
    start_frame();
    send_bytes(POLL, 9, GAP);
    end_frame();
    check_counts("after_rst", a0, f0, c0, 8, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
